bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 139 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble).
// A conversion takes one capture cycle in IDLE, 14 shift iterations and one
// DONE cycle. Operands above 9999 saturate to 9999 and raise overflow.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        ready,
  output logic        valid,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  localparam int          BIN_W     = 14;
  localparam int          BCD_W     = 16;
  localparam logic [3:0]  LAST_ITER = 4'd13;
  localparam logic [13:0] MAX_LEGAL = 14'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W+BIN_W-1:0] shifted;

  // Pre-shift correction: every digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Saturated result for operands that cannot be shown in four digits.
  function automatic logic [15:0] bcd_saturate();
    return 16'h9999;
  endfunction

  // One double-dabble iteration on the joined {scratch, operand} register.
  always_comb begin
    shifted = {bcd_adjust(scratch_q), operand_q} << 1;
  end

  // Next-state and next-output logic for the converter FSM.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          ready_d   = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The first SHIFT cycle screens the captured operand: an illegal
        // value skips the iterations and saturates, so its valid pulse
        // lands one clock after the capture edge.
        if (cnt_q == 4'd0 && operand_q > MAX_LEGAL) begin
          bcd_d   = bcd_saturate();
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          scratch_d = shifted[BCD_W+BIN_W-1:BIN_W];
          operand_d = shifted[BIN_W-1:0];
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == LAST_ITER) begin
            bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
            ovf_d   = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: vector table, corner sequences, random
// operands against an arithmetic reference, and a back-to-back stream.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        ready;
  logic        valid;
  logic [15:0] bcd_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready),
    .valid    (valid),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    int x;
    logic [15:0] r;
    x = (v > 9999) ? 9999 : v;
    r[15:12] = 4'((x / 1000) % 10);
    r[11:8]  = 4'((x / 100) % 10);
    r[7:4]   = 4'((x / 10) % 10);
    r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  // Model of the downstream BCD-to-binary converter.
  function automatic int bcd_to_bin(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("wait_ready_timeout", 32'(ready), 32'd1);
  endtask

  // Start one conversion and check result, latency and the cycle after.
  // glitch_at >= 0 pulses start with bin_in=7 at that cycle offset.
  task automatic conv(input string name, input logic [13:0] v, input logic [15:0] eb,
                      input logic eo, input int lat, input int glitch_at,
                      output logic [15:0] got);
    int n;
    bit seen;
    wait_ready();
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom_range(0, 16383));
    seen = 0;
    got  = bcd_out;
    for (n = 0; n < 40; n++) begin
      if (valid === 1'b1) begin
        seen = 1;
        break;
      end
      if (n == glitch_at) begin
        start  = 1'b1;
        bin_in = 14'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      got = bcd_out;
      chk({name, "_lat"}, 32'(n), 32'(lat));
      chk({name, "_bcd"}, 32'(bcd_out), 32'(eb));
      chk({name, "_ovf"}, 32'(overflow), 32'(eo));
      @(negedge clk);
      chk({name, "_ready_after"}, 32'(ready), 32'd1);
      chk({name, "_valid_drop"}, 32'(valid), 32'd0);
      chk({name, "_hold"}, 32'(bcd_out), 32'(eb));
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [13:0] q[$];
    logic [13:0] nv;
    int last, nval, v;
    bit digits_ok, ready_stuck, any_valid;

    vecs[0] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0, lat: 14};
    vecs[1] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0, lat: 14};
    vecs[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0, lat: 14};
    vecs[3] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1, lat: 1};
    vecs[4] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1, lat: 1};
    vecs[5] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0, lat: 14};
    vecs[6] = '{bin: 14'd8090,  bcd: 16'h8090, ovf: 1'b0, lat: 14};

    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].lat, -1, got);
    end

    // start while busy plus bin_in changes are ignored
    conv("busy_start", 14'd66, 16'h0066, 1'b0, 14, 5, got);

    // reset in the middle of a conversion
    wait_ready();
    start = 1'b1; bin_in = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    any_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid === 1'b1) any_valid = 1;
      @(negedge clk);
    end
    chk("abort_no_valid", 32'(any_valid), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    conv("after_abort", 14'd25, 16'h0025, 1'b0, 14, -1, got);

    // start coinciding with reset is discarded
    rst = 1'b1; start = 1'b1; bin_in = 14'd500;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    any_valid = 0; ready_stuck = 1;
    for (int i = 0; i < 20; i++) begin
      if (valid === 1'b1) any_valid = 1;
      if (ready !== 1'b1) ready_stuck = 0;
      @(negedge clk);
    end
    chk("rst_start_no_valid", 32'(any_valid), 32'd0);
    chk("rst_start_ready", 32'(ready_stuck), 32'd1);

    // sweep into the BCD-to-binary converter model
    for (int i = 0; i < 50; i++) begin
      conv($sformatf("sweep%0d", i), 14'(i), ref_bcd(i), 1'b0, 14, -1, got);
      chk($sformatf("chain%0d", i), 32'(bcd_to_bin(got)), 32'(i));
    end

    // random operands, including illegal ones
    for (int i = 0; i < 40; i++) begin
      v = (i % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      conv($sformatf("rand%0d_v%0d", i, v), 14'(v), ref_bcd(v), v > 9999,
           (v > 9999) ? 1 : 14, -1, got);
      digits_ok = 1;
      for (int d = 0; d < 4; d++) if (got[d*4 +: 4] > 4'd9) digits_ok = 0;
      chk($sformatf("rand%0d_digits", i), 32'(digits_ok), 32'd1);
    end

    // back-to-back conversions with start held high
    wait_ready();
    nv = 14'($urandom_range(0, 9999));
    q.push_back(nv);
    bin_in = nv;
    start  = 1'b1;
    last = -1; nval = 0;
    for (int c = 0; c < 200 && nval < 5; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        chk($sformatf("b2b%0d_bcd", nval), 32'(bcd_out), 32'(ref_bcd(int'(q.pop_front()))));
        if (last >= 0) chk($sformatf("b2b%0d_period", nval), 32'(c - last), 32'd16);
        last = c;
        nval++;
        nv = 14'($urandom_range(0, 9999));
        q.push_back(nv);
        bin_in = nv;
        if (nval == 5) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nval), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
